// File: rtl/fpgafun_pkg.sv
// Shared definitions for the external-pin conditioning blocks.
package fpgafun_pkg;

  // Debounce FSM: qualifying states sit between the two settled levels.
  typedef enum logic [1:0] {
    S_LOW       = 2'b00,
    S_QUAL_HIGH = 2'b01,
    S_HIGH      = 2'b10,
    S_QUAL_LOW  = 2'b11
  } deb_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_debounce_if.sv
// Pin-side signal bundle of the input debouncer.
interface input_debounce_if #(
  parameter int unsigned GLITCH_W = 8
) ();

  logic                pin_i;
  logic                glitch_clr_i;
  logic                level_o;
  logic                rise_o;
  logic                fall_o;
  logic [GLITCH_W-1:0] glitch_cnt_o;

  // Driver of the raw pin and the glitch clear; consumer of the clean outputs.
  modport master (
    output pin_i,
    output glitch_clr_i,
    input  level_o,
    input  rise_o,
    input  fall_o,
    input  glitch_cnt_o
  );

  // The debouncer itself.
  modport slave (
    input  pin_i,
    input  glitch_clr_i,
    output level_o,
    output rise_o,
    output fall_o,
    output glitch_cnt_o
  );

endinterface

// File: rtl/input_debounce_sync2.sv
// Two-flop synchroniser for one asynchronous external pin.
module sync2 (
  input  logic CLK_IN,
  input  logic RST_N_IN,
  input  logic d_i,
  output logic q_o
);

  logic sync1;
  logic sync0;

  // Metastability chain; only sync0 is safe to use downstream.
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      sync1 <= 1'b0;
      sync0 <= 1'b0;
    end else begin
      sync1 <= d_i;
      sync0 <= sync1;
    end
  end

  assign q_o = sync0;

endmodule

// File: rtl/input_debounce.sv
// Debounces one external pin: synchronise, qualify each level change over
// STABLE_CYCLES identical samples, emit level plus registered edge strobes,
// and count aborted qualifications in a saturating glitch counter.
module input_debounce
  import fpgafun_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned GLITCH_W      = 8
) (
  input logic             CLK_IN,
  input logic             RST_N_IN,
  input_debounce_if.slave pins
);

  localparam int unsigned         CntW      = cnt_width(STABLE_CYCLES);
  localparam logic [CntW-1:0]     CntMax    = CntW'(STABLE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GlitchMax = '1;

  logic                s;
  deb_state_e          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                glitch_inc;

  sync2 u_sync2 (
    .CLK_IN   (CLK_IN),
    .RST_N_IN (RST_N_IN),
    .d_i      (pins.pin_i),
    .q_o      (s)
  );

  // State, qualification counter, strobes and glitch counter registers.
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      state_q  <= S_LOW;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  // Next-state logic: a qualifying state either completes, counts on, or
  // falls back to the settled level and records a glitch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (s) begin
          state_d = S_QUAL_HIGH;
          cnt_d   = CntW'(1);
        end
      end
      S_QUAL_HIGH: begin
        if (!s) begin
          state_d    = S_LOW;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CntMax) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_HIGH: begin
        if (!s) begin
          state_d = S_QUAL_LOW;
          cnt_d   = CntW'(1);
        end
      end
      S_QUAL_LOW: begin
        if (s) begin
          state_d    = S_HIGH;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CntMax) begin
          state_d = S_LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Glitch counter: clear wins over increment, increment saturates.
  always_comb begin
    glitch_d = glitch_q;
    if (pins.glitch_clr_i) begin
      glitch_d = '0;
    end else if (glitch_inc && (glitch_q != GlitchMax)) begin
      glitch_d = glitch_q + GLITCH_W'(1);
    end
  end

  // Level is decoded from the registered state, so it moves only on
  // completed qualifications and has no path from any input.
  assign pins.level_o      = (state_q == S_HIGH) || (state_q == S_QUAL_LOW);
  assign pins.rise_o       = rise_q;
  assign pins.fall_o       = fall_q;
  assign pins.glitch_cnt_o = glitch_q;

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with STABLE_CYCLES=4, GLITCH_W=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_input_debounce;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  input_debounce_if #(.GLITCH_W(8)) dbg_if ();

  input_debounce #(
    .STABLE_CYCLES (4),
    .GLITCH_W      (8)
  ) dut (
    .CLK_IN   (clk),
    .RST_N_IN (rst_n),
    .pins     (dbg_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compares {level, rise, fall, glitch_cnt} in one go.
  task automatic check_o(input string tag, input logic l, input logic r, input logic f,
                         input logic [7:0] g);
    check(tag, {21'd0, dbg_if.level_o, dbg_if.rise_o, dbg_if.fall_o, dbg_if.glitch_cnt_o},
          {21'd0, l, r, f, g});
  endtask

  task automatic check_quiet(input string tag);
    check(tag, {29'd0, dbg_if.level_o, dbg_if.rise_o, dbg_if.fall_o}, 32'd0);
  endtask

  initial begin
    rst_n               = 1'b0;
    dbg_if.pin_i        = 1'b0;
    dbg_if.glitch_clr_i = 1'b0;
    #2 check_o("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    step(2);
    rst_n = 1'b1;

    // Pin low for 20 cycles: nothing moves.
    for (int i = 0; i < 20; i++) begin
      step();
      check_o("idle_low", 1'b0, 1'b0, 1'b0, 8'd0);
    end

    // Rising edge: first edge after the pin change is E; outputs move at E+5.
    dbg_if.pin_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_o("rise_wait", 1'b0, 1'b0, 1'b0, 8'd0);
    end
    step();
    check_o("rise", 1'b1, 1'b1, 1'b0, 8'd0);
    step();
    check_o("rise_done", 1'b1, 1'b0, 1'b0, 8'd0);
    step(3);
    check_o("high_hold", 1'b1, 1'b0, 1'b0, 8'd0);

    // Two-cycle low glitch while high: level holds, one glitch counted.
    dbg_if.pin_i = 1'b0;
    step(2);
    dbg_if.pin_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("high_glitch_lvl", {30'd0, dbg_if.level_o, dbg_if.fall_o}, 32'd2);
    end
    check_o("high_glitch", 1'b1, 1'b0, 1'b0, 8'd1);

    // Falling edge mirrors the rise.
    dbg_if.pin_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_o("fall_wait", 1'b1, 1'b0, 1'b0, 8'd1);
    end
    step();
    check_o("fall", 1'b0, 1'b0, 1'b1, 8'd1);
    step();
    check_o("fall_done", 1'b0, 1'b0, 1'b0, 8'd1);

    // Plain clear.
    dbg_if.glitch_clr_i = 1'b1;
    step();
    dbg_if.glitch_clr_i = 1'b0;
    check_o("clr", 1'b0, 1'b0, 1'b0, 8'd0);

    // Five 3-cycle high pulses from S_LOW: all rejected.
    for (int k = 0; k < 5; k++) begin
      dbg_if.pin_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step();
        check_quiet("g3_quiet_hi");
      end
      dbg_if.pin_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
        step();
        check_quiet("g3_quiet_lo");
      end
    end
    check_o("glitch5", 1'b0, 1'b0, 1'b0, 8'd5);

    // Exactly 4 cycles high on s: accepted, level high for 4 cycles.
    dbg_if.pin_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_quiet("p4_wait");
    end
    dbg_if.pin_i = 1'b0;
    step();
    check_quiet("p4_wait2");
    step();
    check_o("p4_rise", 1'b1, 1'b1, 1'b0, 8'd5);
    for (int i = 0; i < 3; i++) begin
      step();
      check_o("p4_high", 1'b1, 1'b0, 1'b0, 8'd5);
    end
    step();
    check_o("p4_fall", 1'b0, 1'b0, 1'b1, 8'd5);
    step();
    check_o("p4_done", 1'b0, 1'b0, 1'b0, 8'd5);

    // 300 one-cycle glitches: counter saturates at 255.
    for (int k = 0; k < 300; k++) begin
      dbg_if.pin_i = 1'b1;
      step();
      dbg_if.pin_i = 1'b0;
      step(3);
      if (k == 248) check("pre_sat", {24'd0, dbg_if.glitch_cnt_o}, 32'd254);
      if (k == 249) check("at_sat", {24'd0, dbg_if.glitch_cnt_o}, 32'd255);
    end
    check_o("sat", 1'b0, 1'b0, 1'b0, 8'd255);

    // Clear coinciding with an increment: clear wins.
    dbg_if.pin_i = 1'b1;
    step();
    dbg_if.pin_i = 1'b0;
    step(2);
    check_o("sat_hold", 1'b0, 1'b0, 1'b0, 8'd255);
    dbg_if.glitch_clr_i = 1'b1;
    step();
    dbg_if.glitch_clr_i = 1'b0;
    check_o("clr_coinc", 1'b0, 1'b0, 1'b0, 8'd0);
    step(3);
    check_o("clr_stays", 1'b0, 1'b0, 1'b0, 8'd0);

    // Leave one glitch counted so the async reset has something to clear.
    dbg_if.pin_i = 1'b1;
    step();
    dbg_if.pin_i = 1'b0;
    step(3);
    check_o("pre_rst", 1'b0, 1'b0, 1'b0, 8'd1);

    // Reset in S_QUAL_HIGH with cnt=3 (after edge E+4), pin held high.
    dbg_if.pin_i = 1'b1;
    step(5);
    check_o("qual3", 1'b0, 1'b0, 1'b0, 8'd1);
    #2 rst_n = 1'b0;
    #1 check_o("async_rst", 1'b0, 1'b0, 1'b0, 8'd0);
    step();
    check_o("in_rst", 1'b0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_o("rerise_wait", 1'b0, 1'b0, 1'b0, 8'd0);
    end
    step();
    check_o("rerise", 1'b1, 1'b1, 1'b0, 8'd0);
    step();
    check_o("rerise_done", 1'b1, 1'b0, 1'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
